// File: rtl/sram_pic_wr.sv
// Bit-serial picture writer: deserialises an LSB-first pixel bit stream, packs
// P_DW bits per SRAM word and writes each completed word with a one-cycle
// active-low strobe at consecutive addresses starting from P_START_ADDR.
module sram_pic_wr #(
    parameter int unsigned      P_AW         = 8,
    parameter logic [P_AW-1:0]  P_START_ADDR = '0,
    parameter int unsigned      P_DW         = 128,
    parameter int unsigned      P_PIX_W      = 8,
    parameter int unsigned      P_PIC_SIZE   = 256
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            i_sop,
    input  logic            i_vld,
    input  logic            i_bit,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic            o_sram_cen,
    output logic            o_sram_wen,
    output logic [P_AW-1:0] o_sram_addr,
    output logic [P_DW-1:0] o_sram_wdata
);

    localparam int unsigned N_WORDS = P_PIC_SIZE * P_PIX_W / P_DW;
    localparam int unsigned BCW     = (P_DW > 1) ? $clog2(P_DW) : 1;
    localparam int unsigned WCW     = $clog2(N_WORDS + 1);

    localparam logic [BCW-1:0] BitLast = BCW'(P_DW - 1);
    localparam logic [WCW-1:0] WordEnd = WCW'(N_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic [P_DW-1:0] pack_q, pack_d;
    logic            err_q, err_d;
    logic            strobe_q, strobe_d;
    logic [P_AW-1:0] addr_q, addr_d;
    logic [P_DW-1:0] wdata_q, wdata_d;

    // Next-state logic: bit packing, word completion, error detection.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        pack_d     = pack_q;
        err_d      = err_q;
        strobe_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (i_vld) begin
                    err_d = 1'b1;
                end
                // Clearing the error on an accepted start wins over a
                // simultaneous stray valid.
                if (i_sop) begin
                    state_d    = StRecv;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end

            StRecv: begin
                if (i_sop) begin
                    err_d = 1'b1;
                end
                if (word_cnt_q == WordEnd) begin
                    // Last word is being strobed this cycle; picture is
                    // complete, so any further bit is a protocol error.
                    if (i_vld) begin
                        err_d = 1'b1;
                    end
                    state_d = StDone;
                end else if (i_vld) begin
                    pack_d[bit_cnt_q] = i_bit;
                    if (bit_cnt_q == BitLast) begin
                        strobe_d   = 1'b1;
                        wdata_d    = pack_d;
                        addr_d     = P_START_ADDR + P_AW'(word_cnt_q);
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end

            StDone: begin
                if (i_sop || i_vld) begin
                    err_d = 1'b1;
                end
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            pack_q     <= '0;
            err_q      <= 1'b0;
            strobe_q   <= 1'b0;
            addr_q     <= P_START_ADDR;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            pack_q     <= pack_d;
            err_q      <= err_d;
            strobe_q   <= strobe_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Outputs are all taken straight from registers.
    always_comb begin
        o_busy       = (state_q != StIdle);
        o_done       = (state_q == StDone);
        o_err        = err_q;
        o_sram_cen   = ~strobe_q;
        o_sram_wen   = ~strobe_q;
        o_sram_addr  = addr_q;
        o_sram_wdata = wdata_q;
    end

endmodule

// File: tb/tb_sram_pic_wr.sv
// Self-checking bench for sram_pic_wr: random pictures and gaps, checked
// against a packing model built directly from the pixel array.
module tb_sram_pic_wr;

    localparam int AW    = 8;
    localparam int DW    = 128;
    localparam int NW    = 16;
    localparam int NPIX  = 256;
    localparam int NBITS = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_sop = 1'b0;
    logic i_vld = 1'b0;
    logic i_bit = 1'b0;

    logic          busy, done, err, cen, wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy_w, done_w, err_w, cen_w, wen_w;
    logic [AW-1:0] addr_w;
    logic [DW-1:0] wdata_w;

    sram_pic_wr dut (
        .CLK(clk), .RST(rst_n), .i_sop(i_sop), .i_vld(i_vld), .i_bit(i_bit),
        .o_busy(busy), .o_done(done), .o_err(err), .o_sram_cen(cen),
        .o_sram_wen(wen), .o_sram_addr(addr), .o_sram_wdata(wdata)
    );

    sram_pic_wr #(.P_START_ADDR(8'hF8)) dut_w (
        .CLK(clk), .RST(rst_n), .i_sop(i_sop), .i_vld(i_vld), .i_bit(i_bit),
        .o_busy(busy_w), .o_done(done_w), .o_err(err_w), .o_sram_cen(cen_w),
        .o_sram_wen(wen_w), .o_sram_addr(addr_w), .o_sram_wdata(wdata_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_edge = 0;
    logic [7:0] pix [NPIX];

    // Edge counter and strobe/done monitor (written only here).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] a_q [$];
    logic [DW-1:0] d_q [$];
    int            s_cyc_q [$];
    logic [AW-1:0] aw_q [$];
    logic [DW-1:0] dw_q [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int wide_cnt = 0;
    bit prev_stb = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!cen && !wen) begin
                a_q.push_back(addr);
                d_q.push_back(wdata);
                s_cyc_q.push_back(cyc);
            end
            if (!cen_w && !wen_w) begin
                aw_q.push_back(addr_w);
                dw_q.push_back(wdata_w);
            end
            if (prev_stb && !cen) wide_cnt <= wide_cnt + 1;
            prev_stb <= !cen;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end else begin
            prev_stb <= 1'b0;
        end
    end

    // Model: word w holds pixels 16w..16w+15, pixel 0 in the LSBs.
    function automatic logic [DW-1:0] exp_word(input int w);
        logic [DW-1:0] m;
        for (int k = 0; k < DW / 8; k++) m[8*k +: 8] = pix[w * (DW / 8) + k];
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pic();
        i_sop = 1'b1;
        step();
        i_sop = 1'b0;
    endtask

    task automatic send_bits(input int from, input int to, input int gap_pct);
        for (int b = from; b < to; b++) begin
            while (int'($urandom_range(99)) < gap_pct) step();
            i_vld = 1'b1;
            i_bit = pix[b / 8][b % 8];
            step();
            i_vld = 1'b0;
        end
        last_edge = cyc;
    endtask

    // Leaves the bench in the cycle after the o_done pulse.
    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done) ok = 1'b1;
            else step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done_timeout: o_done not seen within 20 cycles", name);
        end
        step();
    endtask

    task automatic check_words(input string name, input int base);
        checks++;
        if (a_q.size() !== base + NW) begin
            errors++;
            $display("FAIL %s_strobes: got %0d expected %0d", name, a_q.size() - base, NW);
        end
        for (int w = 0; w < NW && base + w < a_q.size(); w++) begin
            checks++;
            if (a_q[base + w] !== AW'(w)) begin
                errors++;
                $display("FAIL %s_addr[%0d]: got %0h expected %0h", name, w, a_q[base + w], w);
            end
            checks++;
            if (d_q[base + w] !== exp_word(w)) begin
                errors++;
                $display("FAIL %s_data[%0d]: got %h expected %h", name, w, d_q[base + w],
                         exp_word(w));
            end
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic rand_pix();
        for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        step();
        step();
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_err", err, 1'b0);
        check_bit("rst_cen", cen, 1'b1);
        check_bit("rst_wen", wen, 1'b1);
        checks++;
        if (addr !== 8'h00 || wdata !== '0 || addr_w !== 8'hF8) begin
            errors++;
            $display("FAIL rst_addr_data: got %h/%h/%h expected 00/0/f8", addr, wdata, addr_w);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_nominal();
        int base = a_q.size();
        int dbase = done_cnt;
        int wbase = wide_cnt;
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(i);
        start_pic();
        check_bit("nom_busy_after_sop", busy, 1'b1);
        send_bits(0, NBITS, 0);
        wait_done("nom");
        check_words("nom", base);
        checks++;
        if (d_q.size() >= base + NW &&
            (d_q[base] !== 128'h0F0E0D0C0B0A09080706050403020100 ||
             d_q[base + 15] !== 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0)) begin
            errors++;
            $display("FAIL nom_literal_words: got %h / %h", d_q[base], d_q[base + 15]);
        end
        checks++;
        if (done_cnt - dbase !== 1 || done_cyc !== last_edge + 1) begin
            errors++;
            $display("FAIL nom_done: got count %0d at edge %0d expected 1 at %0d",
                     done_cnt - dbase, done_cyc, last_edge + 1);
        end
        checks++;
        if (s_cyc_q.size() >= base + NW &&
            (s_cyc_q[base + 15] !== last_edge ||
             s_cyc_q[base + 15] - s_cyc_q[base] !== 15 * DW)) begin
            errors++;
            $display("FAIL nom_strobe_timing: got last %0d span %0d expected %0d span %0d",
                     s_cyc_q[base + 15], s_cyc_q[base + 15] - s_cyc_q[base], last_edge, 15 * DW);
        end
        check_bit("nom_err", err, 1'b0);
        check_bit("nom_busy_end", busy, 1'b0);
        checks++;
        if (wide_cnt !== wbase) begin
            errors++;
            $display("FAIL nom_strobe_width: got %0d wide strobes expected 0", wide_cnt - wbase);
        end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 2; r++) begin
            int base = a_q.size();
            int dbase = done_cnt;
            int wbase = wide_cnt;
            if (r == 0) for (int i = 0; i < NPIX; i++) pix[i] = 8'(i);
            else rand_pix();
            start_pic();
            send_bits(0, NBITS, 30);
            wait_done("gap");
            check_words("gap", base);
            checks++;
            if (done_cnt - dbase !== 1 || wide_cnt !== wbase) begin
                errors++;
                $display("FAIL gap_done_width: got done %0d wide %0d expected 1 and 0",
                         done_cnt - dbase, wide_cnt - wbase);
            end
            check_bit("gap_err", err, 1'b0);
        end
    endtask

    task automatic test_wrap();
        int base = aw_q.size();
        rand_pix();
        start_pic();
        send_bits(0, NBITS, 10);
        wait_done("wrap");
        checks++;
        if (aw_q.size() !== base + NW) begin
            errors++;
            $display("FAIL wrap_strobes: got %0d expected %0d", aw_q.size() - base, NW);
        end
        for (int w = 0; w < NW && base + w < aw_q.size(); w++) begin
            logic [AW-1:0] ea = AW'(248 + w);
            checks++;
            if (aw_q[base + w] !== ea || dw_q[base + w] !== exp_word(w)) begin
                errors++;
                $display("FAIL wrap_word[%0d]: got %h/%h expected %h/%h", w, aw_q[base + w],
                         dw_q[base + w], ea, exp_word(w));
            end
        end
    endtask

    task automatic test_errors();
        int base = a_q.size();
        int dbase;
        // Stray valid in IDLE.
        i_vld = 1'b1;
        i_bit = 1'b1;
        step();
        i_vld = 1'b0;
        step();
        check_bit("err_vld_idle", err, 1'b1);
        check_bit("err_vld_idle_busy", busy, 1'b0);
        checks++;
        if (a_q.size() !== base) begin
            errors++;
            $display("FAIL err_vld_idle_strobe: got %0d strobes expected 0", a_q.size() - base);
        end
        // Accepted start clears the error; stray start mid-picture sets it.
        rand_pix();
        dbase = done_cnt;
        start_pic();
        check_bit("err_clear_on_sop", err, 1'b0);
        send_bits(0, 100, 0);
        i_sop = 1'b1;
        step();
        i_sop = 1'b0;
        step();
        check_bit("err_sop_recv", err, 1'b1);
        send_bits(100, NBITS, 20);
        wait_done("err");
        check_words("err_pic", base);
        check_bit("err_sticky", err, 1'b1);
        checks++;
        if (done_cnt - dbase !== 1) begin
            errors++;
            $display("FAIL err_done_count: got %0d expected 1", done_cnt - dbase);
        end
        // Start plus valid together: start wins, bit dropped, error cleared.
        base = a_q.size();
        rand_pix();
        i_sop = 1'b1;
        i_vld = 1'b1;
        i_bit = 1'b1;
        step();
        i_sop = 1'b0;
        i_vld = 1'b0;
        check_bit("err_sop_vld_err", err, 1'b0);
        check_bit("err_sop_vld_busy", busy, 1'b1);
        send_bits(0, NBITS, 0);
        wait_done("err2");
        check_words("err_sop_vld_pic", base);
    endtask

    task automatic test_reset_mid();
        int base = a_q.size();
        rand_pix();
        start_pic();
        send_bits(0, 300, 0);
        rst_n = 1'b0;
        #1;
        check_bit("rmid_cen", cen, 1'b1);
        check_bit("rmid_wen", wen, 1'b1);
        check_bit("rmid_busy", busy, 1'b0);
        check_bit("rmid_done", done, 1'b0);
        check_bit("rmid_err", err, 1'b0);
        checks++;
        if (addr !== 8'h00 || wdata !== '0) begin
            errors++;
            $display("FAIL rmid_addr_data: got %h/%h expected 00/0", addr, wdata);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (a_q.size() !== base + 2) begin
            errors++;
            $display("FAIL rmid_partial: got %0d strobes expected 2", a_q.size() - base);
        end
        base = a_q.size();
        rand_pix();
        start_pic();
        send_bits(0, NBITS, 15);
        wait_done("rmid");
        check_words("rmid_pic", base);
    endtask

    task automatic test_back_to_back();
        int base = a_q.size();
        int dbase = done_cnt;
        bit ok = 1'b0;
        rand_pix();
        start_pic();
        send_bits(0, NBITS, 0);
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done) ok = 1'b1;
            else step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_done_timeout: o_done not seen within 20 cycles");
        end
        step();
        start_pic();
        check_bit("b2b_err", err, 1'b0);
        check_bit("b2b_busy", busy, 1'b1);
        check_words("b2b_first", base);
        base = a_q.size();
        rand_pix();
        send_bits(0, NBITS, 0);
        wait_done("b2b");
        check_words("b2b_second", base);
        check_bit("b2b_err_end", err, 1'b0);
        checks++;
        if (done_cnt - dbase !== 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - dbase);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gaps();
        test_wrap();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_pic_wr.md
# sram_pic_wr

Bit-serial picture writer that sits directly downstream of the pixel-stream generator. It deserializes an LSB-first stream of 8-bit pixels and packs P_DW/8 pixels per word. Each completed word is written to the picture SRAM through a single-cycle, active-low write strobe, at consecutive addresses from P_START_ADDR. It signals completion after exactly one picture (P_PIC_SIZE pixels).

## Interface
- P_START_ADDR, 8'd0, SRAM address of the first word.
- P_AW, 8, SRAM address width.
- P_DW, 128, SRAM data width; must be a multiple of P_PIX_W.
- P_PIX_W, 8, pixel width in bits.
- P_PIC_SIZE, 256, pixels per picture; P_PIC_SIZE*P_PIX_W must be a multiple of P_DW.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- i_sop  in  1  one-cycle start-of-picture pulse.
- i_vld  in  1  i_bit is valid this cycle.
- i_bit  in  1  serial pixel bit, LSB first within each pixel.
- o_busy  out  1  high in RECV and DONE.
- o_done  out  1  one-cycle pulse after the last write of a picture.
- o_err  out  1  sticky protocol-error flag.
- o_sram_cen  out  1  SRAM chip enable, active low.
- o_sram_wen  out  1  SRAM write enable, active low.
- o_sram_addr  out  P_AW  SRAM word address.
- o_sram_wdata  out  P_DW  SRAM write data.

## Operation
- Reset values: state IDLE, counters 0, shift register 0, o_busy=0, o_done=0, o_err=0, o_sram_cen=1, o_sram_wen=1, o_sram_addr=P_START_ADDR, o_sram_wdata=0.
- Derived constant: N_WORDS = P_PIC_SIZE*P_PIX_W/P_DW (16 at the defaults).
- FSM has three states: IDLE, RECV and DONE.
- IDLE -> RECV on i_sop. On entry, clear the bit counter (log2 P_DW bits), the word counter and o_err.
- RECV: each i_vld cycle stores i_bit at position bit_cnt of the packing register, then increments bit_cnt. Gaps in i_vld (i_vld=0) hold all state.
- Packing rule: pixel k of a word occupies bits [P_PIX_W*k+P_PIX_W-1 : P_PIX_W*k]. Pixel bit j lands at bit P_PIX_W*k+j. Pixel 0 is at the LSBs.
- Word completion: when i_vld is high and bit_cnt = P_DW-1:
  - on the next edge, load o_sram_wdata with the complete word (including the current bit);
  - drive o_sram_cen=0 and o_sram_wen=0 for exactly one cycle;
  - set o_sram_addr = P_START_ADDR + word_cnt, truncated to P_AW bits (wraps modulo 2^P_AW);
  - bit_cnt wraps to 0 and word_cnt increments.
- RECV -> DONE on completion of word N_WORDS-1. In DONE, o_done=1 for one cycle; then go to IDLE.
- Outside a write strobe, o_sram_addr and o_sram_wdata hold their last values.
- Errors (set o_err; the offending event is otherwise ignored):
  - i_sop while not in IDLE; the current picture continues unaffected;
  - i_vld while in IDLE or DONE; the bit is dropped.
- o_err stays high until reset or the next accepted i_sop.
- Simultaneous i_sop and i_vld in IDLE: i_sop is accepted, i_vld is an error, and the bit is dropped. The o_err clear on entry takes priority, so o_err ends up 0.
- Reset mid-picture: all state returns to reset values immediately. The partial word is discarded and no strobe is issued.

## Timing
- i_sop at edge t: o_busy=1 from t+1.
- Bit accepted at edge t with bit_cnt=P_DW-1: write strobe is active in the cycle after t, with wdata and addr valid in that same cycle.
- Last word: strobe in cycle t+1, o_done in cycle t+2, o_busy=0 from t+3.
- Streaming without gaps: strobes occur every P_DW cycles. The block never stalls upstream and needs no backpressure.
- Full default picture without gaps: 2048 bits, 16 strobes, o_done 2 cycles after the last bit edge.

## Test plan
- Nominal picture: pixel values 0..255, streamed LSB-first with no gaps, P_START_ADDR=0 -> 16 strobes at addresses 0..15. Word 0 = 128'h0F0E0D0C0B0A09080706050403020100; word 15 = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0. Single o_done pulse, o_err=0.
- Random i_vld gaps (30% idle cycles) with the same data -> identical 16 words and addresses. Strobe count is 16, each exactly one cycle wide.
- P_START_ADDR=8'hF8 -> addresses F8..FF, then 00..07 (wrap-around).
- i_sop pulsed in RECV after 100 bits, and i_vld pulsed in IDLE -> o_err=1 and sticky, picture data unchanged. The next i_sop clears o_err.
- RST asserted after 300 bits (mid word 2) -> outputs at reset values immediately. A new i_sop plus a full picture then yields the correct 16 words from P_START_ADDR.
- Back-to-back pictures: i_sop in the cycle after o_done -> accepted, second picture written from P_START_ADDR again, no o_err.
